// File: rtl/four_12_12_st3_bias_ctrl.sv
// Bias memory load/read controller: fills a single-port bias RAM from a load stream while
// arbitrating datapath reads, with a starvation override so loading always makes progress.
module four_12_12_st3_bias_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              loaded,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

    localparam logic [ADDR_W-1:0] LastAddr   = '1;
    localparam logic [2:0]        StarveMax  = 3'd4;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]        starve_q, starve_d;
    logic              loaded_q, loaded_d;
    logic              rd_valid_q;

    logic in_load, wr_pending, wr_override, wr_accept;

    // Arbitration: reads win unless a pending write has lost four cycles in a row.
    always_comb begin
        in_load     = (state_q == StLoad);
        wr_pending  = in_load && ld_valid && !ld_start;
        wr_override = wr_pending && (starve_q == StarveMax);
        rd_gnt      = reset && rd_req && !wr_override;
        ld_ready    = reset && in_load && !ld_start && !rd_gnt;
        wr_accept   = ld_ready && ld_valid;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        starve_d = starve_q;
        loaded_d = loaded_q;
        if (ld_start) begin
            state_d  = StLoad;
            wr_ptr_d = '0;
            starve_d = '0;
            loaded_d = 1'b0;
        end else if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            starve_d = '0;
            if (wr_ptr_q == LastAddr) begin
                state_d  = StReady;
                loaded_d = 1'b1;
            end
        end else if (wr_pending) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            starve_q   <= '0;
            loaded_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            starve_q   <= starve_d;
            loaded_q   <= loaded_d;
            rd_valid_q <= rd_gnt;
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (wr_accept) begin
            mem_wr_en   = 1'b1;
            mem_addr    = wr_ptr_q;
            mem_wr_data = ld_data;
        end else if (rd_gnt) begin
            mem_rd_en = 1'b1;
            mem_addr  = rd_addr;
        end
    end

    assign loaded   = loaded_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_rd_data;

endmodule

// File: tb/tb_four_12_12_st3_bias_ctrl.sv
// Self-checking bench: randomized directed steps against a transaction-level model of the
// bias loader, with a behavioural single-port RAM attached to the memory port.
module tb_four_12_12_st3_bias_ctrl;

    logic        clk = 1'b0;
    logic        reset, ld_start, ld_valid, ld_ready, loaded;
    logic [31:0] ld_data;
    logic        rd_req, rd_gnt, rd_valid;
    logic [3:0]  rd_addr, mem_addr;
    logic [31:0] rd_data, mem_wr_data, mem_rd_data;
    logic        mem_wr_en, mem_rd_en;

    four_12_12_st3_bias_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .loaded(loaded), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    // Reference model: what has been loaded, where the load is, how long writes have waited.
    bit          in_load, loaded_m, prev_gnt, prev_def;
    int          ptr, starved;
    logic [31:0] refm [16];
    bit          defined [16];
    logic [31:0] prev_data;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [31:0] d,
                        input bit q, input logic [3:0] a);
        bit          pend, e_gnt, e_rdy, e_wr;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        reset = r; ld_start = s; ld_valid = v; ld_data = d; rd_req = q; rd_addr = a;
        pend   = r && in_load && v && !s;
        e_gnt  = r && q && !(pend && starved == 4);
        e_rdy  = r && in_load && !s && !e_gnt;
        e_wr   = e_rdy && v;
        e_addr = e_wr ? 4'(ptr) : (e_gnt ? a : 4'd0);
        e_data = e_wr ? d : 32'd0;
        @(negedge clk);
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, e_rdy});
        chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, e_gnt});
        chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e_wr});
        chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, e_gnt});
        chk("mem_addr", {28'd0, mem_addr}, {28'd0, e_addr});
        chk("mem_wr_data", mem_wr_data, e_data);
        chk("loaded", {31'd0, loaded}, {31'd0, loaded_m});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, prev_gnt});
        chk("strobe_excl", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);
        if (prev_gnt && prev_def) chk("rd_data", rd_data, prev_data);
        @(posedge clk);
        if (!r) begin
            in_load = 0; ptr = 0; starved = 0; loaded_m = 0; prev_gnt = 0;
        end else begin
            prev_gnt = e_gnt;
            if (e_gnt) begin
                prev_def  = defined[a];
                prev_data = refm[a];
            end
            if (s) begin
                in_load = 1; ptr = 0; starved = 0; loaded_m = 0;
            end else if (e_wr) begin
                refm[ptr] = d;
                defined[ptr] = 1;
                if (ptr == 15) begin
                    in_load = 0;
                    loaded_m = 1;
                end
                ptr = (ptr + 1) % 16;
                starved = 0;
            end else if (pend) begin
                starved++;
            end else begin
                starved = 0;
            end
        end
        #1;
    endtask

    initial begin
        reset = 0; ld_start = 0; ld_valid = 0; ld_data = 0; rd_req = 0; rd_addr = 0;
        for (int i = 0; i < 16; i++) defined[i] = 0;
        in_load = 0; loaded_m = 0; prev_gnt = 0; prev_def = 0; ptr = 0; starved = 0;
        prev_data = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset holds all outputs low even with activity on the inputs.
        for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1, $urandom, 1, 4'($urandom));

        // Full load, no reads.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, 32'h100 + i, 0, 0);
        chk("loaded_after_full", {31'd0, loaded}, 32'd1);

        // Read latency at address 5.
        step(1, 0, 0, 0, 1, 4'd5);
        chk("rd5_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd5_data", rd_data, 32'h105);
        for (int i = 0; i < 20; i++) step(1, 0, 1'($urandom), $urandom, 1'($urandom), 4'($urandom));

        // Starvation: loads and reads both held high.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 1, $urandom, 1, 4'($urandom));

        // Restart after 7 words.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 1, $urandom, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, $urandom, 1'($urandom_range(0, 3) == 0), 4'($urandom));
        step(1, 0, 0, 0, 0, 0);

        // ld_start coincident with ld_valid, then a fresh write must land at address 0.
        step(1, 1, 1, 32'hdead_beef, 0, 0);
        step(1, 0, 1, 32'h5a5a_0000, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 1, $urandom, 0, 0);

        // Mid-load reset at word 9; ld_valid is then ignored until ld_start.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 1, $urandom, 0, 0);
        step(0, 0, 1, $urandom, 1, 4'($urandom));
        for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, $urandom, 0, 0);

        // Random mix.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom), $urandom, 1'($urandom), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/four_12_12_st3_bias_ctrl.md
FOUR_12_12_ST3_BIAS_CTRL -- requirements
Module: four_12_12_st3_bias_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: bias memory address width; depth = 2^ADDR_W = 16 entries.
REQ-002 Parameter DATA_W, default 32: bias word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 ld_start  in  1  pulse: begin, or restart, a full bias load.
REQ-006 ld_valid  in  1  load word valid.
REQ-007 ld_data  in  DATA_W  load word.
REQ-008 ld_ready  out  1  load word accepted when ld_valid && ld_ready.
REQ-009 loaded  out  1  level: all 2^ADDR_W entries written since the last ld_start.
REQ-010 rd_req  in  1  datapath read request.
REQ-011 rd_addr  in  ADDR_W  datapath read index.
REQ-012 rd_gnt  out  1  read accepted this cycle; combinational.
REQ-013 rd_valid  out  1  registered; rd_data is valid this cycle.
REQ-014 rd_data  out  DATA_W  read word; equals mem_rd_data.
REQ-015 mem_wr_en, mem_rd_en  out  1 each  single-port memory strobes; never both high.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wr_data  out  DATA_W  memory write data.
REQ-018 mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_rd_en.

Function
REQ-019 FSM states: IDLE, LOAD, READY.
REQ-020 IDLE -> LOAD on ld_start; READY -> LOAD on ld_start.
REQ-021 LOAD -> LOAD on ld_start: wr_ptr restarts at 0.
REQ-022 Entering LOAD: wr_ptr = 0, loaded = 0.
REQ-023 LOAD -> READY on the accepted write at wr_ptr = 2^ADDR_W-1; loaded = 1 from the next cycle.
REQ-024 ld_ready = 1 only in LOAD, with ld_start low, and when the write wins arbitration.
REQ-025 Accepted write: mem_wr_en = 1, mem_addr = wr_ptr, mem_wr_data = ld_data; wr_ptr increments by 1.
REQ-026 Arbitration priority: datapath read normally wins over a pending write; pending write = LOAD && ld_valid && !ld_start.
REQ-027 Starvation counter, 3 bits: increments each cycle a pending write loses; cleared on any accepted write or when no write is pending.
REQ-028 Starvation override: when the counter = 4, the write wins, rd_gnt = 0, and the requester holds rd_req/rd_addr.
REQ-029 rd_gnt = rd_req && !(write override); reads are granted in every state, including IDLE, where the data is undefined.
REQ-030 Granted read: mem_rd_en = 1, mem_addr = rd_addr.
REQ-031 rd_valid = 1 exactly one cycle after rd_gnt.
REQ-032 Back-to-back reads: one granted read per cycle; throughput 1/cycle.
REQ-033 No memory access cycle: mem_wr_en = mem_rd_en = 0, mem_addr = 0, mem_wr_data = 0.
REQ-034 ld_valid outside LOAD is ignored; ld_ready = 0.
REQ-035 ld_start coincident with ld_valid: no write that cycle; wr_ptr = 0 next cycle.
REQ-036 Estimated size: 120-200 RTL lines.

Reset
REQ-037 While reset = 0 at a clock edge, the block holds these values: state IDLE, wr_ptr 0, starvation counter 0, loaded 0, rd_valid 0.
REQ-038 While reset = 0, all outputs are 0: ld_ready, rd_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data.
REQ-039 Reset asserted mid-LOAD abandons the load; after release, loaded = 0 until a full new load completes.

Verification
REQ-040 Full load: ld_start, then 16 words 0x100+i with ld_valid held and no reads -> ld_ready = 1 each cycle, mem_addr 0..15, loaded = 1 the cycle after word 15.
REQ-041 Read latency: after the load, rd_req with rd_addr = 5 -> rd_gnt same cycle; next cycle rd_valid = 1, rd_data = 0x105.
REQ-042 Starvation: LOAD with ld_valid and rd_req both held high -> reads granted 4 cycles, 5th cycle write accepted with rd_gnt = 0; pattern repeats; mem_wr_en and mem_rd_en never both high.
REQ-043 Restart: ld_start after 7 words -> loaded stays 0, next write at address 0, and loaded rises only after 16 further writes.
REQ-044 Simultaneous: ld_start and ld_valid in the same cycle -> ld_ready = 0, no mem write, wr_ptr = 0.
REQ-045 Mid-load reset: reset low for 1 cycle during word 9 -> all outputs 0, state IDLE, ld_valid ignored until ld_start.
